// File: rtl/sample_sequencer.sv
// sample_sequencer: presents stored training vectors to a neuron, one sample
// every HOLD_CYCLES clocks, looping over the active samples for MAX_EPOCHS epochs.
// Ports: clk/rst_n (sync, active-low); wr_* table write port (idle/done only);
//        start/num_samples/pause control; in_vec/expected/sample_strobe/
//        sample_idx/epoch/busy/done registered outputs.
module sample_sequencer #(
  parameter int N_INPUTS    = 32,
  parameter int N_SAMPLES   = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_EPOCHS  = 1000,
  localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1,
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_addr,
  input  logic [N_INPUTS-1:0] wr_data,
  input  logic                wr_expected,
  input  logic [IW:0]         num_samples,
  input  logic                start,
  input  logic                pause,
  output logic [N_INPUTS-1:0] in_vec,
  output logic                expected,
  output logic                sample_strobe,
  output logic [IW-1:0]       sample_idx,
  output logic [15:0]         epoch,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

  localparam logic [31:0] MAX_E = MAX_EPOCHS;

  // Sample table: deliberately outside the reset domain so contents survive rst_n.
  logic [N_INPUTS-1:0] tbl_vec_q [N_SAMPLES];
  logic                tbl_exp_q [N_SAMPLES];

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [15:0]         epoch_q, epoch_d;
  logic [IW:0]         count_q, count_d;
  logic [N_INPUTS-1:0] vec_q, vec_d;
  logic                exp_q, exp_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                start_ok;
  logic                idx_last;
  logic                hold_last;
  logic [15:0]         epoch_inc;
  logic [IW-1:0]       idx_nxt;

  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE || state_q == S_DONE)) begin
      tbl_vec_q[wr_addr] <= wr_data;
      tbl_exp_q[wr_addr] <= wr_expected;
    end
  end

  always_comb begin
    start_ok  = start && (num_samples != '0) && (num_samples <= (IW+1)'(N_SAMPLES));
    idx_last  = ({1'b0, idx_q} == (count_q - (IW+1)'(1)));
    hold_last = (hold_q == HW'(HOLD_CYCLES - 1));
    epoch_inc = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
    idx_nxt   = idx_q + IW'(1);

    state_d  = state_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    epoch_d  = epoch_q;
    count_d  = count_q;
    vec_d    = vec_q;
    exp_d    = exp_q;
    strobe_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // pause is irrelevant here; a valid start always wins.
        if (start_ok) begin
          state_d  = S_RUN;
          count_d  = num_samples;
          idx_d    = '0;
          epoch_d  = '0;
          hold_d   = '0;
          vec_d    = tbl_vec_q[0];
          exp_d    = tbl_exp_q[0];
          strobe_d = 1'b1;
        end
      end
      S_RUN: begin
        if (pause) begin
          // The cycle that sees pause does not advance the hold counter.
          state_d = S_PAUSED;
        end else if (!hold_last) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d = '0;
          if (idx_last) begin
            epoch_d = epoch_inc;
            if ({16'd0, epoch_inc} == MAX_E) begin
              // Finished: idx holds, epoch shows the final count.
              state_d = S_DONE;
              vec_d   = '0;
              exp_d   = 1'b0;
            end else begin
              idx_d    = '0;
              vec_d    = tbl_vec_q[0];
              exp_d    = tbl_exp_q[0];
              strobe_d = 1'b1;
            end
          end else begin
            idx_d    = idx_nxt;
            vec_d    = tbl_vec_q[idx_nxt];
            exp_d    = tbl_exp_q[idx_nxt];
            strobe_d = 1'b1;
          end
        end
      end
      S_PAUSED: begin
        if (!pause) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      idx_q    <= '0;
      epoch_q  <= '0;
      count_q  <= '0;
      vec_q    <= '0;
      exp_q    <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      idx_q    <= idx_d;
      epoch_q  <= epoch_d;
      count_q  <= count_d;
      vec_q    <= vec_d;
      exp_q    <= exp_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign in_vec        = vec_q;
  assign expected      = exp_q;
  assign sample_strobe = strobe_q;
  assign sample_idx    = idx_q;
  assign epoch         = epoch_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: scoreboard bench for sample_sequencer (16 x 32-bit table,
// hold 4, 3 epochs). Stimulus pushes expected presentations; a negedge monitor
// pops one per sample_strobe and checks vector, index, epoch and strobe spacing.
module tb_sample_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_expected;
  logic [4:0]  num_samples;
  logic        start;
  logic        pause;
  logic [31:0] in_vec;
  logic        expected;
  logic        sample_strobe;
  logic [3:0]  sample_idx;
  logic [15:0] epoch;
  logic        busy;
  logic        done;

  sample_sequencer #(
    .N_INPUTS(32), .N_SAMPLES(16), .HOLD_CYCLES(4), .MAX_EPOCHS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_expected(wr_expected), .num_samples(num_samples),
    .start(start), .pause(pause), .in_vec(in_vec), .expected(expected),
    .sample_strobe(sample_strobe), .sample_idx(sample_idx), .epoch(epoch),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] vec;
    logic        exp;
    logic [15:0] ep;
    logic [15:0] gap;   // cycles since previous strobe; 0 = first of a run
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mvec [16];
  logic        mexp [16];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t0 = 0;
  int          prev_cyc = 0;
  logic [31:0] last_vec = '0;
  logic        last_exp = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  // Monitor: one scoreboard pop per strobe; between strobes while busy the
  // presented vector must not move.
  always @(negedge clk) begin
    if (sample_strobe === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: got strobe idx=%0d ep=%0d at cycle %0d, required no strobe",
                 sample_idx, epoch, cyc);
      end else begin
        automatic sb_t it = sb.pop_front();
        if (sample_idx !== it.idx || in_vec !== it.vec || expected !== it.exp ||
            epoch !== it.ep || (it.gap != 0 && (cyc - prev_cyc) != int'(it.gap))) begin
          n_err++;
          $display("FAIL strobe_item: got idx=%0d vec=%h exp=%b ep=%0d gap=%0d, required idx=%0d vec=%h exp=%b ep=%0d gap=%0d",
                   sample_idx, in_vec, expected, epoch, cyc - prev_cyc,
                   it.idx, it.vec, it.exp, it.ep, it.gap);
        end
      end
      last_vec = in_vec;
      last_exp = expected;
      prev_cyc = cyc;
    end else if (busy === 1'b1) begin
      n_cmp++;
      if (in_vec !== last_vec || expected !== last_exp) begin
        n_err++;
        $display("FAIL hold_stable: got vec=%h exp=%b at cycle %0d, required vec=%h exp=%b",
                 in_vec, expected, cyc, last_vec, last_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_tbl(input logic [3:0] a, input logic [31:0] d, input logic e);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_expected = e;
    tick(1);
    wr_en = 1'b0;
  endtask

  // Returns in the first cycle after the start edge (first RUN cycle if accepted).
  task automatic do_start(input logic [4:0] n, input logic p);
    start = 1'b1; num_samples = n; pause = p;
    tick(1);
    start = 1'b0; pause = 1'b0;
    t0 = cyc;
  endtask

  task automatic push_run(input int n, input int n_ep);
    for (int e = 0; e < n_ep; e++)
      for (int i = 0; i < n; i++)
        sb.push_back({4'(i), mvec[i], mexp[i], 16'(e), ((e == 0 && i == 0) ? 16'd0 : 16'd4)});
  endtask

  task automatic wait_done(input string name, input int limit, input int req);
    int waited = 0;
    while (done !== 1'b1 && waited < limit) begin
      tick(1);
      waited++;
    end
    if (done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: done not seen within %0d cycles, required after %0d", name, limit, req);
    end else begin
      chk(name, 64'(cyc - t0), 64'(req));
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_in_vec"}, 64'(in_vec), 64'd0);
    chk({p, "_expected"}, 64'(expected), 64'd0);
    chk({p, "_strobe"}, 64'(sample_strobe), 64'd0);
    chk({p, "_idx"}, 64'(sample_idx), 64'd0);
    chk({p, "_epoch"}, 64'(epoch), 64'd0);
    chk({p, "_busy"}, 64'(busy), 64'd0);
    chk({p, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_expected = 1'b0;
    num_samples = '0; start = 1'b0; pause = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mvec[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
      mexp[i] = i[0];
    end
    mvec[0] = 32'h1; mexp[0] = 1'b1;
    mvec[1] = 32'h0; mexp[1] = 1'b0;

    tick(3);
    rst_n = 1'b1;
    check_reset("por");

    for (int i = 0; i < 16; i++) write_tbl(4'(i), mvec[i], mexp[i]);

    // Out-of-range counts are ignored.
    do_start(5'd0, 1'b0);
    chk("start0_busy", 64'(busy), 64'd0);
    chk("start0_done", 64'(done), 64'd0);
    do_start(5'd17, 1'b0);
    chk("start17_busy", 64'(busy), 64'd0);

    // Two samples, three epochs; pause held with start must not block it.
    push_run(2, 3);
    do_start(5'd2, 1'b1);
    chk("runA_busy", 64'(busy), 64'd1);
    wait_done("runA_done_cycle", 100, 24);
    chk("runA_epoch", 64'(epoch), 64'd3);
    chk("runA_in_vec", 64'(in_vec), 64'd0);
    chk("runA_idx", 64'(sample_idx), 64'd1);
    chk("runA_busy_end", 64'(busy), 64'd0);
    tick(3);
    chk("runA_drained", 64'(sb.size()), 64'd0);

    do_start(5'd0, 1'b0);
    chk("done_start0_done", 64'(done), 64'd1);

    // Write during RUN is dropped; pause raised in the hold-2 cycle of sample 1
    // for 5 cycles: that cycle plus 5 paused cycles make no progress, then
    // hold 2 and 3 run, so sample 1 spans 10 cycles and done lands 6 late.
    push_run(2, 3);
    sb[2].gap = 16'd10;
    do_start(5'd2, 1'b0);
    tick(1);
    write_tbl(4'd0, 32'hFFFF_FFFF, 1'b0);
    tick(4);
    pause = 1'b1;
    tick(2);
    chk("pause_busy", 64'(busy), 64'd1);
    chk("pause_idx", 64'(sample_idx), 64'd1);
    chk("pause_strobe", 64'(sample_strobe), 64'd0);
    tick(3);
    pause = 1'b0;
    wait_done("runB_done_cycle", 100, 30);
    chk("runB_epoch", 64'(epoch), 64'd3);
    tick(2);
    chk("runB_drained", 64'(sb.size()), 64'd0);

    // All 16 samples in order; reset mid-sample 2 of epoch 2.
    push_run(16, 2);
    for (int i = 0; i < 3; i++) sb.push_back({4'(i), mvec[i], mexp[i], 16'd2, 16'd4});
    do_start(5'd16, 1'b0);
    tick(138);
    chk("runC_epoch_before_rst", 64'(epoch), 64'd2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_reset("midrun_rst");
    chk("runC_drained", 64'(sb.size()), 64'd0);

    // Table contents survive reset.
    push_run(2, 3);
    do_start(5'd2, 1'b0);
    wait_done("runD_done_cycle", 100, 24);
    tick(2);
    chk("runD_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
